wb_data_responder: RTL and testbench

- Responder (slave) end of the data/port bus driven by the control unit's MEM_STATE (data_cyc_o/data_stb_o/data_we_o, waits on data_ack_i).
- Single-port data RAM behind a Wishbone-classic handshake, with a programmable wait-state count and an error response for unmapped addresses.
- Sits between the datapath's address/data lines and storage; answers one transfer at a time.

---
 rtl/wb_pkg.sv | 29 ++
 rtl/data_ram_sp.sv | 33 +++
 rtl/wb_data_responder.sv | 150 +++++++++++++++
 tb/tb_wb_data_responder.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared bus definitions for the data/port bus: responder FSM states,
// wait-state limits and the control unit's memory-access state encodings.
package wb_pkg;

  // Responder FSM states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } wb_state_e;

  // Bus-side states of the control unit's MEM_STATE sequencer
  typedef enum logic [1:0] {
    MEM_IDLE  = 2'd0,
    MEM_REQ   = 2'd1,
    MEM_WAIT  = 2'd2,
    MEM_DONE  = 2'd3
  } cu_mem_state_e;

  // Largest legal wait-state count and the counter width that holds it
  localparam int WAIT_MAX   = 15;
  localparam int WAIT_CNT_W = $clog2(WAIT_MAX + 1);

  // RAM address width, never narrower than one bit
  function automatic int ramAddrW(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/data_ram_sp.sv
// Single-port synchronous data RAM with a registered read port.
// The read register only updates on read accesses, so it holds the last
// value read across writes and idle cycles. Contents are never reset.
module data_ram_sp #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256,
  parameter int AW     = 8
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic              i_we,
  input  logic [AW-1:0]     i_addr,
  input  logic [DATA_W-1:0] i_din,
  output logic [DATA_W-1:0] o_dout
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_dout;

  // Write the array or capture a read word, one access per enabled cycle
  always_ff @(posedge clk) begin
    if (i_en) begin
      if (i_we) begin
        r_mem[i_addr] <= i_din;
      end else begin
        r_dout <= r_mem[i_addr];
      end
    end
  end

  assign o_dout = r_dout;

endmodule

// File: rtl/wb_data_responder.sv
// Wishbone-classic responder in front of the data RAM. Accepts one transfer
// at a time, inserts WAIT_CYCLES wait states, then answers with a one-cycle
// ack (mapped address) or err (unmapped address).
module wb_data_responder
  import wb_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 8,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cyc_i,
  input  logic              stb_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] adr_i,
  input  logic [DATA_W-1:0] dat_i,
  output logic [DATA_W-1:0] dat_o,
  output logic              ack_o,
  output logic              err_o,
  output logic              busy_o
);

  localparam int RAM_AW = ramAddrW(DEPTH);
  localparam logic [WAIT_CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES > 0) ? WAIT_CNT_W'(WAIT_CYCLES - 1) : '0;
  localparam logic [ADDR_W:0] DEPTH_CMP = (ADDR_W + 1)'(DEPTH);

  wb_state_e r_state;
  wb_state_e w_nextState;
  logic [WAIT_CNT_W-1:0] r_cnt;
  logic [WAIT_CNT_W-1:0] w_nextCnt;
  logic w_enterResp;

  logic              r_we;
  logic [ADDR_W-1:0] r_adr;
  logic [DATA_W-1:0] r_dat;

  logic              r_ack;
  logic              r_err;
  logic              r_datValid;

  logic              w_req;
  logic              w_xferWe;
  logic [ADDR_W-1:0] w_xferAdr;
  logic [DATA_W-1:0] w_xferDat;
  logic              w_inRange;
  logic              w_ramEn;
  logic [DATA_W-1:0] w_ramDout;

  assign w_req = cyc_i & stb_i;

  // With zero wait states RESP is entered on the sampling edge itself, so
  // the live bus values are used there; otherwise the latched copy is used
  assign w_xferWe  = (r_state == IDLE) ? we_i  : r_we;
  assign w_xferAdr = (r_state == IDLE) ? adr_i : r_adr;
  assign w_xferDat = (r_state == IDLE) ? dat_i : r_dat;
  assign w_inRange = ({1'b0, w_xferAdr} < DEPTH_CMP);

  // The RAM is touched only on the RESP entry edge; reset blocks the write
  assign w_ramEn = w_enterResp & w_inRange & ~rst;

  // Next-state and wait-counter logic
  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_enterResp = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_req) begin
          if (WAIT_CYCLES > 0) begin
            w_nextState = WAIT;
            w_nextCnt   = CNT_INIT;
          end else begin
            w_nextState = RESP;
            w_enterResp = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!cyc_i) begin
          w_nextState = IDLE;
          w_nextCnt   = '0;
        end else if (r_cnt == '0) begin
          w_nextState = RESP;
          w_enterResp = 1'b1;
        end else begin
          w_nextCnt = r_cnt - WAIT_CNT_W'(1);
        end
      end
      RESP: begin
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
        w_nextCnt   = '0;
      end
    endcase
  end

  // State, counter and response flag registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_datValid <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_cnt   <= w_nextCnt;
      r_ack   <= w_enterResp & w_inRange;
      r_err   <= w_enterResp & ~w_inRange;
      if (w_enterResp && w_inRange && !w_xferWe) begin
        r_datValid <= 1'b1;
      end
    end
  end

  // Capture the request on the sampling edge so later bus changes are ignored
  always_ff @(posedge clk) begin
    if (r_state == IDLE && w_req) begin
      r_we  <= we_i;
      r_adr <= adr_i;
      r_dat <= dat_i;
    end
  end

  data_ram_sp #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (RAM_AW)
  ) u_ram (
    .clk    (clk),
    .i_en   (w_ramEn),
    .i_we   (w_xferWe),
    .i_addr (w_xferAdr[RAM_AW-1:0]),
    .i_din  (w_xferDat),
    .o_dout (w_ramDout)
  );

  // Read data is zero until the first read after reset, then the RAM's
  // read register, which only changes on reads
  assign dat_o  = r_datValid ? w_ramDout : '0;
  assign ack_o  = r_ack;
  assign err_o  = r_err;
  assign busy_o = (r_state != IDLE);

endmodule

// File: tb/tb_wb_data_responder.sv
// Self-checking bench for wb_data_responder. Five instances with different
// wait-state counts and depths share one clock; each has its own bus.
module tb_wb_data_responder;

  localparam int NI = 5;

  // Wait states and depth of each instance
  function automatic int wcOf(input int k);
    case (k)
      0: return 2;
      1: return 0;
      2: return 3;
      3: return 1;
      default: return 5;
    endcase
  endfunction

  function automatic int dpOf(input int k);
    case (k)
      0: return 128;
      3: return 200;
      default: return 256;
    endcase
  endfunction

  logic clk = 1'b0;
  logic       rstv [NI];
  logic       cyc  [NI];
  logic       stb  [NI];
  logic       we   [NI];
  logic [7:0] adr  [NI];
  logic [7:0] din  [NI];
  logic [7:0] dout [NI];
  logic       ack  [NI];
  logic       err  [NI];
  logic       busy [NI];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NI; g++) begin : g_dut
    wb_data_responder #(
      .DATA_W      (8),
      .ADDR_W      (8),
      .DEPTH       (dpOf(g)),
      .WAIT_CYCLES (wcOf(g))
    ) u_dut (
      .clk    (clk),
      .rst    (rstv[g]),
      .cyc_i  (cyc[g]),
      .stb_i  (stb[g]),
      .we_i   (we[g]),
      .adr_i  (adr[g]),
      .dat_i  (din[g]),
      .dat_o  (dout[g]),
      .ack_o  (ack[g]),
      .err_o  (err[g]),
      .busy_o (busy[g])
    );
  end

  typedef struct {
    int         k;
    bit         expErr;
    logic [7:0] expDat;
    int         expLat;
  } exp_t;

  typedef struct {
    int         k;
    bit         w;
    logic [7:0] a;
    logic [7:0] d;
    bit         eErr;
    logic [7:0] eDat;
    string      name;
  } vec_t;

  exp_t sbQ[$];
  int checks = 0;
  int failures = 0;
  int ackCount [NI];
  logic [7:0] mem [NI][256];
  logic [7:0] lastRd [NI];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Drive one transfer, push its expectation, wait for the response and compare
  task automatic applyStimulus(input int k, input bit w, input logic [7:0] a, input logic [7:0] d,
                               input bit eErr, input logic [7:0] eDat, input string name);
    exp_t e;
    exp_t p;
    int lat;
    bit got;
    e.k = k; e.expErr = eErr; e.expDat = eDat; e.expLat = wcOf(k) + 1;
    sbQ.push_back(e);
    @(posedge clk); #1;
    cyc[k] = 1'b1; stb[k] = 1'b1; we[k] = w; adr[k] = a; din[k] = d;
    lat = 0; got = 1'b0;
    while (!got && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      if (ack[k] || err[k]) got = 1'b1;
    end
    cyc[k] = 1'b0; stb[k] = 1'b0;
    p = sbQ.pop_front();
    if (!got) begin
      checkOutput({name, " timeout"}, 32'(0), 32'(1));
    end else begin
      checkOutput({name, " err"}, 32'(err[k]), 32'(p.expErr));
      checkOutput({name, " ack"}, 32'(ack[k]), 32'(!p.expErr));
      checkOutput({name, " lat"}, 32'(lat), 32'(p.expLat));
      checkOutput({name, " dat"}, 32'(dout[k]), 32'(p.expDat));
      if (ack[k]) ackCount[k]++;
    end
    @(posedge clk); #1;
    checkOutput({name, " pulse"}, 32'({ack[k], err[k], busy[k]}), 32'(0));
  endtask

  // Reference model: expected response of one transfer, then update state
  task automatic modelStep(input int k, input bit w, input logic [7:0] a, input logic [7:0] d,
                           output bit eErr, output logic [7:0] eDat);
    eErr = !(int'(a) < dpOf(k));
    eDat = lastRd[k];
    if (!eErr) begin
      if (w) mem[k][a] = d;
      else begin
        eDat = mem[k][a];
        lastRd[k] = eDat;
      end
    end
  endtask

  vec_t vecs[$];

  initial begin
    int firstAck, secondAck, extra;
    logic [7:0] d1, d2;
    bit sawResp;
    int expInRange [NI];

    for (int k = 0; k < NI; k++) begin
      rstv[k] = 1'b1; cyc[k] = 1'b0; stb[k] = 1'b0; we[k] = 1'b0;
      adr[k] = '0; din[k] = '0; ackCount[k] = 0; lastRd[k] = '0; expInRange[k] = 0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < NI; k++) rstv[k] = 1'b0;
    for (int k = 0; k < NI; k++) begin
      checkOutput($sformatf("reset%0d", k), 32'({ack[k], err[k], busy[k], dout[k]}), 32'(0));
    end

    vecs.push_back('{0, 1'b1, 8'h10, 8'hA5, 1'b0, 8'h00, "wr10"});
    vecs.push_back('{0, 1'b0, 8'h10, 8'h00, 1'b0, 8'hA5, "rd10"});
    vecs.push_back('{0, 1'b0, 8'h80, 8'h00, 1'b1, 8'hA5, "rd80err"});
    vecs.push_back('{0, 1'b1, 8'h90, 8'h33, 1'b1, 8'hA5, "wr90err"});
    vecs.push_back('{0, 1'b0, 8'h10, 8'h00, 1'b0, 8'hA5, "rd10old"});
    vecs.push_back('{0, 1'b1, 8'h7F, 8'h42, 1'b0, 8'hA5, "wr7F"});
    vecs.push_back('{0, 1'b0, 8'h7F, 8'h00, 1'b0, 8'h42, "rd7F"});
    vecs.push_back('{1, 1'b1, 8'h01, 8'h11, 1'b0, 8'h00, "wc0wr01"});
    vecs.push_back('{1, 1'b1, 8'h02, 8'h22, 1'b0, 8'h00, "wc0wr02"});
    vecs.push_back('{2, 1'b1, 8'h20, 8'h5A, 1'b0, 8'h00, "wc3wr20"});
    vecs.push_back('{3, 1'b1, 8'hC7, 8'h9E, 1'b0, 8'h00, "d200wrC7"});
    vecs.push_back('{3, 1'b0, 8'hC8, 8'h00, 1'b1, 8'h00, "d200rdC8err"});
    vecs.push_back('{3, 1'b0, 8'hC7, 8'h00, 1'b0, 8'h9E, "d200rdC7"});
    vecs.push_back('{4, 1'b1, 8'h30, 8'h77, 1'b0, 8'h00, "wc5wr30"});
    vecs.push_back('{4, 1'b0, 8'h30, 8'h00, 1'b0, 8'h77, "wc5rd30"});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].k, vecs[i].w, vecs[i].a, vecs[i].d, vecs[i].eErr, vecs[i].eDat, vecs[i].name);
      if (!vecs[i].eErr) begin
        if (vecs[i].w) mem[vecs[i].k][vecs[i].a] = vecs[i].d;
        else lastRd[vecs[i].k] = vecs[i].eDat;
      end
    end

    // Back-to-back reads with zero wait states and the request held high
    @(posedge clk); #1;
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b0; adr[1] = 8'h01;
    firstAck = -1; secondAck = -1; extra = 0; d1 = '0; d2 = '0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk); #1;
      if (ack[1]) begin
        if (firstAck < 0) begin
          firstAck = c; d1 = dout[1]; adr[1] = 8'h02;
        end else if (secondAck < 0) begin
          secondAck = c; d2 = dout[1]; cyc[1] = 1'b0; stb[1] = 1'b0;
        end else extra++;
      end
    end
    cyc[1] = 1'b0; stb[1] = 1'b0;
    checkOutput("b2b first", 32'(firstAck), 32'(1));
    checkOutput("b2b gap", 32'(secondAck - firstAck), 32'(2));
    checkOutput("b2b extra", 32'(extra), 32'(0));
    checkOutput("b2b dat1", 32'(d1), 32'(8'h11));
    checkOutput("b2b dat2", 32'(d2), 32'(8'h22));
    lastRd[1] = 8'h22;

    // Abort by dropping cyc_i in the second wait cycle; stb_i alone stays high
    @(posedge clk); #1;
    cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 8'h20; din[2] = 8'h3C;
    sawResp = 1'b0;
    @(posedge clk); #1;
    sawResp |= ack[2] | err[2];
    checkOutput("abort busy1", 32'(busy[2]), 32'(1));
    @(posedge clk); #1;
    sawResp |= ack[2] | err[2];
    checkOutput("abort busy2", 32'(busy[2]), 32'(1));
    cyc[2] = 1'b0;
    @(posedge clk); #1;
    sawResp |= ack[2] | err[2];
    checkOutput("abort busy3", 32'(busy[2]), 32'(0));
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      sawResp |= ack[2] | err[2] | busy[2];
    end
    stb[2] = 1'b0;
    checkOutput("abort noresp", 32'(sawResp), 32'(0));
    applyStimulus(2, 1'b0, 8'h20, 8'h00, 1'b0, 8'h5A, "abort rd20");

    // Reset one cycle after a write is accepted
    @(posedge clk); #1;
    cyc[4] = 1'b1; stb[4] = 1'b1; we[4] = 1'b1; adr[4] = 8'h30; din[4] = 8'h99;
    @(posedge clk); #1;
    checkOutput("rstmid busy pre", 32'(busy[4]), 32'(1));
    rstv[4] = 1'b1; cyc[4] = 1'b0; stb[4] = 1'b0;
    @(posedge clk); #1;
    rstv[4] = 1'b0;
    checkOutput("rstmid busy", 32'(busy[4]), 32'(0));
    checkOutput("rstmid dat", 32'(dout[4]), 32'(0));
    sawResp = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      sawResp |= ack[4] | err[4];
    end
    checkOutput("rstmid noack", 32'(sawResp), 32'(0));
    lastRd[4] = '0;
    applyStimulus(4, 1'b0, 8'h30, 8'h00, 1'b0, 8'h77, "rstmid rd30");
    lastRd[4] = 8'h77;

    // Random traffic against the model on instances with 0, 1 and 5 wait states
    for (int a = 0; a < 16; a++) begin
      bit eE;
      logic [7:0] eD;
      for (int j = 0; j < 3; j++) begin
        int k;
        logic [7:0] dv;
        k = (j == 0) ? 1 : (j == 1) ? 3 : 4;
        dv = 8'($urandom_range(0, 255));
        modelStep(k, 1'b1, 8'(a), dv, eE, eD);
        applyStimulus(k, 1'b1, 8'(a), dv, eE, eD, "init");
      end
    end
    for (int k = 0; k < NI; k++) ackCount[k] = 0;
    for (int n = 0; n < 200; n++) begin
      int k;
      int sel;
      bit w;
      logic [7:0] a;
      logic [7:0] dv;
      bit eE;
      logic [7:0] eD;
      sel = $urandom_range(0, 2);
      k = (sel == 0) ? 1 : (sel == 1) ? 3 : 4;
      w = 1'($urandom_range(0, 1));
      if (k == 3 && $urandom_range(0, 3) == 0) a = 8'($urandom_range(200, 255));
      else a = 8'($urandom_range(0, 15));
      dv = 8'($urandom_range(0, 255));
      modelStep(k, w, a, dv, eE, eD);
      if (!eE) expInRange[k]++;
      applyStimulus(k, w, a, dv, eE, eD, $sformatf("rnd%0d k%0d", n, k));
    end
    checkOutput("rnd acks k1", 32'(ackCount[1]), 32'(expInRange[1]));
    checkOutput("rnd acks k3", 32'(ackCount[3]), 32'(expInRange[3]));
    checkOutput("rnd acks k4", 32'(ackCount[4]), 32'(expInRange[4]));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
